// File: rtl/filter_loader.sv
`default_nettype none

`ifndef WID_FILTER
`define WID_FILTER 16
`endif

// ============================================================================
//  Module   : filter_loader
//  Purpose  : Write-side sequencer for the convolver filter buffer. On an
//             accepted start it reads nine consecutive weights from filter
//             memory (base .. base+8, wrapping modulo 2^ADDR_W) and streams
//             them one per cycle into the 9-stage filter shift buffer. A
//             one-entry skid register absorbs read data that returns while
//             the buffer is held, so no in-flight word is lost.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             start,base_addr - load request (IDLE only) and weight-0 address
//             hold            - downstream stall, suppresses shifting
//             mem_rd_en/addr  - filter memory read strobe / address
//             mem_rd_data     - read data, valid one cycle after mem_rd_en
//             shifting, out_w - shift enable and weight to the filter buffer
//             busy, done      - load in progress / one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module filter_loader #(
    parameter int WID    = `WID_FILTER,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WID-1:0]    mem_rd_data,
    output logic              shifting,
    output logic [WID-1:0]    out_w,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] c_NUM_TAPS = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr_last;   // mem_addr holds this when no read issues
    logic [3:0]        r_ic;          // reads issued
    logic [3:0]        r_sc;          // weights shifted
    logic              r_rv;          // read data returning this cycle
    logic              r_skid_vld;
    logic [WID-1:0]    r_skid_data;

    logic              w_start_acc;
    logic              w_issue;
    logic              w_shift;

    assign w_start_acc = (r_state == S_IDLE) && start;

    // A full skid blocks issue so that a held return always finds room:
    // at most one word is ever parked while the buffer is stalled.
    assign w_issue = (r_state == S_FETCH) && (r_ic < c_NUM_TAPS) &&
                     !hold && !r_skid_vld;

    assign w_shift = (r_skid_vld || r_rv) && !hold;

    assign mem_rd_en = w_issue;
    assign mem_addr  = w_issue ? (r_base + ADDR_W'(r_ic)) : r_addr_last;
    assign shifting  = w_shift;

    // Skid data is older than anything returning, so it has priority.
    always_comb begin
        out_w = '0;
        if (r_skid_vld) begin
            out_w = r_skid_data;
        end else if (r_rv) begin
            out_w = mem_rd_data;
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                // Leave once the ninth weight shifts at this edge.
                if (w_shift && (r_sc == c_NUM_TAPS - 4'd1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_addr_last <= '0;
            r_ic        <= '0;
            r_sc        <= '0;
            r_rv        <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rv    <= w_issue;

            if (w_start_acc) begin
                r_base <= base_addr;
                r_ic   <= '0;
                r_sc   <= '0;
            end else begin
                if (w_issue) begin
                    r_ic <= r_ic + 4'd1;
                end
                if (w_shift) begin
                    r_sc <= r_sc + 4'd1;
                end
            end

            if (w_issue) begin
                r_addr_last <= mem_addr;
            end

            // Park a word that returns into a stalled buffer; drain it on
            // the first shift after the stall releases.
            if (r_rv && hold) begin
                r_skid_vld  <= 1'b1;
                r_skid_data <= mem_rd_data;
            end else if (w_shift && r_skid_vld) begin
                r_skid_vld  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_filter_loader.sv
`timescale 1ns/1ps
`default_nettype none

// ============================================================================
//  Module   : tb_filter_loader
//  Purpose  : Self-checking bench for filter_loader. A queue-based model of
//             the read/skid/shift pipeline predicts every output each cycle;
//             directed scenarios add absolute timing and ordering checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_filter_loader;

    localparam int WID = 8;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          hold;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [WID-1:0] mem_rd_data;
    logic          shifting;
    logic [WID-1:0] out_w;
    logic          busy;
    logic          done;

    logic [WID-1:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the most recent run_load call
    int             res_done_cnt;
    int             res_done_first;
    int             res_done_last;
    logic [WID-1:0] res_seq[$];
    logic [AW-1:0]  res_addrs[$];

    always #5 clk = ~clk;

    // Synchronous memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        else           mem_rd_data <= WID'($urandom);
    end

    filter_loader #(.WID(WID), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .hold       (hold),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .shifting   (shifting),
        .out_w      (out_w),
        .busy       (busy),
        .done       (done)
    );

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; hold = 1'b0; base_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives cycles 0..n_cyc-1 (and onward until the model is idle again),
    // comparing every DUT output against the model each cycle.
    task automatic run_load(input logic [AW-1:0] base, input logic [127:0] hold_m,
                            input logic [127:0] start_m, input int n_cyc, input int rst_cyc);
        int             phase = 0, issued = 0, shifted = 0, k = 0;
        logic           infl = 1'b0;
        logic [AW-1:0]  infl_a = '0, last_a = '0, lbase = '0;
        logic [WID-1:0] pend[$];
        logic           arr, e_rd, e_sh;
        logic [WID-1:0] arr_d, e_out;
        logic [AW-1:0]  e_addr;
        res_done_cnt = 0; res_done_first = -1; res_done_last = -1;
        res_seq.delete(); res_addrs.delete();
        while ((k < n_cyc || phase != 0) && k < 200) begin
            start     = (k < n_cyc) ? start_m[k] : 1'b0;
            hold      = (k < 128) ? hold_m[k] : 1'b0;
            rst       = (k == rst_cyc);
            base_addr = start ? base : AW'($urandom);
            arr   = infl;
            arr_d = mem[infl_a];
            e_sh  = !hold && (pend.size() > 0 || arr);
            e_out = (pend.size() > 0) ? pend[0] : (arr ? arr_d : '0);
            e_rd  = (phase == 1) && (issued < 9) && !hold && (pend.size() == 0);
            e_addr = e_rd ? (lbase + AW'(issued)) : last_a;
            @(negedge clk);
            n_checks += 6;
            if (mem_rd_en !== e_rd) begin
                n_fail++; $display("FAIL rd_en cyc %0d: got %b want %b", k, mem_rd_en, e_rd);
            end
            if (mem_addr !== e_addr) begin
                n_fail++; $display("FAIL addr cyc %0d: got %0d want %0d", k, mem_addr, e_addr);
            end
            if (shifting !== e_sh) begin
                n_fail++; $display("FAIL shifting cyc %0d: got %b want %b", k, shifting, e_sh);
            end
            if (out_w !== e_out) begin
                n_fail++; $display("FAIL out_w cyc %0d: got %h want %h", k, out_w, e_out);
            end
            if (busy !== (phase != 0)) begin
                n_fail++; $display("FAIL busy cyc %0d: got %b want %b", k, busy, phase != 0);
            end
            if (done !== (phase == 2)) begin
                n_fail++; $display("FAIL done cyc %0d: got %b want %b", k, done, phase == 2);
            end
            if (rst_cyc >= 0 && k == rst_cyc + 1) begin
                n_checks++;
                if ({mem_rd_en, mem_addr, shifting, out_w, busy, done} !== '0) begin
                    n_fail++;
                    $display("FAIL post_reset_zero cyc %0d: got %b want all 0", k,
                             {mem_rd_en, mem_addr, shifting, out_w, busy, done});
                end
            end
            if (shifting === 1'b1) res_seq.push_back(out_w);
            if (mem_rd_en === 1'b1) res_addrs.push_back(mem_addr);
            if (done === 1'b1) begin
                res_done_cnt++;
                if (res_done_first < 0) res_done_first = k;
                res_done_last = k;
            end
            if (rst) begin
                phase = 0; issued = 0; shifted = 0; infl = 1'b0; infl_a = '0;
                last_a = '0; pend.delete();
            end else begin
                if (arr) pend.push_back(arr_d);
                if (e_sh) begin void'(pend.pop_front()); shifted++; end
                if (e_rd) begin issued++; last_a = e_addr; end
                infl = e_rd; infl_a = e_addr;
                case (phase)
                    0: if (start) begin phase = 1; lbase = base; issued = 0; shifted = 0; end
                    1: if (shifted == 9) phase = 2;
                    default: phase = 0;
                endcase
            end
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: got %0d cycles want <200", k);
        end
        start = 1'b0; hold = 1'b0; rst = 1'b0;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) mem[i] = WID'(i + 8'h10);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({mem_rd_en, mem_addr, shifting, out_w, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all 0",
                     {mem_rd_en, mem_addr, shifting, out_w, busy, done});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        fill_ramp(); do_reset();
        run_load(4'd3, '0, 128'd1, 13, -1);
        n_checks += 2;
        if (res_done_first !== 11) begin
            n_fail++; $display("FAIL basic_done_cycle: got %0d want 11", res_done_first);
        end
        if (res_seq.size() !== 9) begin
            n_fail++; $display("FAIL basic_shift_count: got %0d want 9", res_seq.size());
        end
        for (int i = 0; i < res_seq.size() && i < 9; i++) begin
            n_checks++;
            if (res_seq[i] !== WID'(8'h13 + i)) begin
                n_fail++; $display("FAIL basic_seq[%0d]: got %h want %h", i, res_seq[i], 8'h13 + i);
            end
        end
    endtask

    task automatic test_hold_return();
        fill_ramp(); do_reset();
        run_load(4'd3, 128'd1 << 4, 128'd1, 15, -1);
        n_checks += 2;
        if (res_done_first !== 13) begin
            n_fail++; $display("FAIL hold_ret_done_cycle: got %0d want 13", res_done_first);
        end
        if (res_seq.size() !== 9) begin
            n_fail++; $display("FAIL hold_ret_shift_count: got %0d want 9", res_seq.size());
        end
        for (int i = 0; i < res_seq.size() && i < 9; i++) begin
            n_checks++;
            if (res_seq[i] !== WID'(8'h13 + i)) begin
                n_fail++; $display("FAIL hold_ret_seq[%0d]: got %h want %h", i, res_seq[i], 8'h13 + i);
            end
        end
    endtask

    task automatic test_long_hold();
        fill_ramp(); do_reset();
        run_load(4'd3, 128'h1F << 3, 128'd1, 19, -1);
        n_checks += 2;
        if (res_done_first !== 17) begin
            n_fail++; $display("FAIL long_hold_done_cycle: got %0d want 17", res_done_first);
        end
        if (res_seq.size() !== 9) begin
            n_fail++; $display("FAIL long_hold_shift_count: got %0d want 9", res_seq.size());
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) mem[i] = WID'($urandom);
        do_reset();
        run_load(4'd14, '0, 128'd1, 13, -1);
        n_checks += 2;
        if (res_addrs.size() !== 9) begin
            n_fail++; $display("FAIL wrap_read_count: got %0d want 9", res_addrs.size());
        end
        if (res_seq.size() !== 9) begin
            n_fail++; $display("FAIL wrap_shift_count: got %0d want 9", res_seq.size());
        end
        for (int i = 0; i < 9 && i < res_addrs.size() && i < res_seq.size(); i++) begin
            n_checks += 2;
            if (res_addrs[i] !== AW'((14 + i) % 16)) begin
                n_fail++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, res_addrs[i], (14 + i) % 16);
            end
            if (res_seq[i] !== mem[(14 + i) % 16]) begin
                n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, res_seq[i], mem[(14 + i) % 16]);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_ramp(); do_reset();
        run_load(4'd3, '0, (128'd1 << 7) | 128'd1, 20, 5);
        n_checks += 2;
        if (res_done_cnt !== 1 || res_done_first !== 18) begin
            n_fail++;
            $display("FAIL reset_mid_done: got cnt %0d cyc %0d want cnt 1 cyc 18", res_done_cnt, res_done_first);
        end
        if (res_seq.size() < 9 || res_seq[res_seq.size() - 1] !== 8'h1B) begin
            n_fail++; $display("FAIL reset_mid_reload: got %0d shifts want a full reload ending 1b", res_seq.size());
        end
    endtask

    task automatic test_start_busy();
        fill_ramp(); do_reset();
        run_load(4'd3, '0, 128'd1 | (128'd1 << 4) | (128'd1 << 11) | (128'd1 << 12), 13, -1);
        n_checks += 2;
        if (res_done_cnt !== 2 || res_done_first !== 11) begin
            n_fail++;
            $display("FAIL busy_start_first: got cnt %0d first %0d want cnt 2 first 11", res_done_cnt, res_done_first);
        end
        if (res_done_last !== 23) begin
            n_fail++; $display("FAIL busy_start_second: got %0d want 23", res_done_last);
        end
    endtask

    task automatic test_random();
        logic [127:0] hm, sm;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = WID'($urandom);
            hm = '0; sm = 128'd1;
            for (int i = 0; i < 128; i++) begin
                hm[i] = ($urandom_range(0, 9) < 3);
                if (i > 0) sm[i] = ($urandom_range(0, 9) < 2);
            end
            do_reset();
            run_load(AW'($urandom), hm, sm, 60, -1);
            n_checks++;
            if (res_done_cnt < 1) begin
                n_fail++; $display("FAIL random_%0d_done: got %0d want >=1", r, res_done_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; base_addr = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_hold_return();
        test_long_hold();
        test_wrap();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
